rain_collide: RTL and testbench
===============================

RAIN_COLLIDE -- requirements
Module: rain_collide

Interface
REQ-001 Parameter LIVES, default 3: starting lives per player, legal range 1..3.
REQ-002 Parameter IFRAMES, default 60: frames of hit immunity after a hit, legal range 1..255.
REQ-003 clk  in  1  system clock, the 50 MHz board clock.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 restart  in  1  synchronous, active-low game restart, driven from KEY[0].
REQ-006 frame  in  1  one-cycle tick, asserted once per animation frame.
REQ-007 p1_x, p1_y, p2_x, p2_y  in  8 each  top-left corner of each 2x2 player sprite.
REQ-008 rain_x, rain_y  in  8 each  top-left corner of the 2-wide x 8-tall rain drop.
REQ-009 rain_valid  in  1  high while a rain drop is on screen.
REQ-010 p1_lives, p2_lives  out  2 each  remaining lives.
REQ-011 p1_hit, p2_hit  out  1 each  one-cycle pulse when a life is lost.
REQ-012 game_over  out  1  level signal, high in the over state.
REQ-013 winner  out  2  01 = player 1, 10 = player 2, 11 = tie, 00 = game in progress.

Function
REQ-014 FSM has four states: PLAY, SAMPLE, APPLY and OVER.
REQ-015 PLAY moves to SAMPLE on frame=1; otherwise it holds.
REQ-016 SAMPLE registers all position inputs and rain_valid, then moves to APPLY on the next cycle.
REQ-017 APPLY computes the overlap of the sampled values and applies hits; it then moves to OVER if any player's lives = 0, otherwise to PLAY.
REQ-018 In OVER, frame is ignored and the state holds until restart=0.
REQ-019 Overlap is computed with 9-bit arithmetic and no 8-bit wrap: rx <= px+1 AND px <= rx+1 AND ry <= py+1 AND py <= ry+7. It is forced to 0 when rain_valid=0.
REQ-020 A new drop is detected when sampled rain_y < previous sampled rain_y, or when rain_valid shows a 0->1 transition. A new drop clears both per-player drop_hit latches.
REQ-021 A player is hit in APPLY only when all of these hold: overlap=1, drop_hit=0, immunity counter=0, lives>0.
REQ-022 A hit decrements lives by 1, sets drop_hit, loads the immunity counter with IFRAMES, and pulses pX_hit for exactly one cycle (the APPLY cycle).
REQ-023 Each player's immunity counter decrements by 1 on each frame tick while nonzero and saturates at 0.
REQ-024 Both players may be hit in the same APPLY cycle; both decrement and both hit pulses fire together.
REQ-025 Lives never underflow below 0.
REQ-026 On entry to OVER, winner is latched from the lives values:
- p1_lives=0 and p2_lives=0 -> 11
- p1_lives=0 only -> 10
- p2_lives=0 only -> 01
REQ-027 While not in OVER, winner = 00.
REQ-028 restart=0 in any state, mid-frame included, does all of the following on the next clk edge:
- lives = LIVES for both players
- immunity counters, latches and hit pulses cleared
- winner = 00
- state = PLAY
REQ-029 Restart takes priority over every FSM transition.
REQ-030 Worst-case latency from frame to hit pulse is 2 cycles.

Reset
REQ-031 resetn=0 asynchronously forces every register to its reset value:
- state = PLAY
- p1_lives = p2_lives = LIVES
- p1_hit = p2_hit = 0, game_over = 0, winner = 00
- immunity counters, drop_hit latches and sampled positions = 0
REQ-032 After resetn deasserts, the first frame is processed normally, with no spurious new-drop or hit event.

Structure
REQ-033 A shared package holds the following:
- FSM state encodings
- sprite size constants (PLAYER_W=2, PLAYER_H=2, RAIN_W=2, RAIN_H=8)
- WINNER_* codes
REQ-034 The per-player logic is instantiated twice as sub-module player_hit_tracker. It covers overlap, drop_hit latch, immunity counter and lives.

Verification
REQ-035 Overlap hit: p1=(100,110), rain=(101,104), valid, one frame -> p1_hit pulse 2 cycles after frame, p1_lives 3->2.
REQ-036 Same drop held over 5 frames while still overlapping -> exactly one hit; a new drop with rain_y dropping 118->0 inside immunity -> no hit.
REQ-037 IFRAMES=2, new overlapping drop on the 3rd frame after a hit -> second hit, lives 2->1.
REQ-038 Edge wrap: p2=(254,110), rain=(0,104) -> no hit; rain=(255,104) -> hit.
REQ-039 Both players lose their last life on the same frame -> game_over=1, winner=11; further frames are ignored; restart=0 -> lives=3, winner=00, state PLAY.
REQ-040 resetn pulsed low during APPLY -> all outputs at reset values immediately, with no hit pulse emitted.

Source files
------------

// File: rtl/rain_collide_pkg.sv
// Shared types and constants for the rain-drop collision / lives tracker.
// Holds FSM states, sprite geometry, winner codes and the overlap test.
package rain_collide_pkg;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_APPLY  = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    localparam int unsigned PLAYER_W = 2;
    localparam int unsigned PLAYER_H = 2;
    localparam int unsigned RAIN_W   = 2;
    localparam int unsigned RAIN_H   = 8;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_TIE  = 2'b11;

    // Bounding-box test widened to 9 bits so sprites at the right/bottom edge never wrap to 0.
    function automatic logic sprite_overlap(input logic [7:0] px, input logic [7:0] py,
                                            input logic [7:0] rx, input logic [7:0] ry);
        logic [8:0] px9, py9, rx9, ry9;
        px9 = {1'b0, px};
        py9 = {1'b0, py};
        rx9 = {1'b0, rx};
        ry9 = {1'b0, ry};
        return (rx9 <= px9 + 9'(PLAYER_W - 1)) && (px9 <= rx9 + 9'(RAIN_W - 1)) &&
               (ry9 <= py9 + 9'(PLAYER_H - 1)) && (py9 <= ry9 + 9'(RAIN_H - 1));
    endfunction

endpackage

// File: rtl/rain_collide_player_hit_tracker.sv
// Per-player collision state: overlap, once-per-drop latch, hit immunity and lives.
// The hit pulse is combinational during the APPLY cycle; lives update on its closing edge.
module player_hit_tracker
    import rain_collide_pkg::*;
#(
    parameter int unsigned LIVES   = 3,
    parameter int unsigned IFRAMES = 60
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       restart_ni,
    input  logic       frame_i,
    input  logic       apply_i,
    input  logic       new_drop_i,
    input  logic       rain_valid_i,
    input  logic [7:0] px_i,
    input  logic [7:0] py_i,
    input  logic [7:0] rx_i,
    input  logic [7:0] ry_i,
    output logic [1:0] lives_o,
    output logic [1:0] lives_next_o,
    output logic       hit_o
);

    logic [1:0] lives_q, lives_d;
    logic       drop_hit_q, drop_hit_d;
    logic [7:0] imm_q, imm_d;
    logic       overlap;
    logic       hit;

    always_comb begin
        overlap = rain_valid_i && sprite_overlap(px_i, py_i, rx_i, ry_i);
        // A new drop clears the latch in the same APPLY cycle it is evaluated.
        hit = apply_i && restart_ni && overlap && !(drop_hit_q && !new_drop_i) &&
              (imm_q == '0) && (lives_q != '0);

        lives_d    = lives_q;
        drop_hit_d = drop_hit_q;
        imm_d      = imm_q;
        if (!restart_ni) begin
            lives_d    = 2'(LIVES);
            drop_hit_d = 1'b0;
            imm_d      = '0;
        end else begin
            if (frame_i && (imm_q != '0)) imm_d = imm_q - 8'd1;
            if (apply_i && new_drop_i)    drop_hit_d = 1'b0;
            if (hit) begin
                lives_d    = lives_q - 2'd1;
                drop_hit_d = 1'b1;
                imm_d      = 8'(IFRAMES);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lives_q    <= 2'(LIVES);
            drop_hit_q <= 1'b0;
            imm_q      <= '0;
        end else begin
            lives_q    <= lives_d;
            drop_hit_q <= drop_hit_d;
            imm_q      <= imm_d;
        end
    end

    assign lives_o      = lives_q;
    assign lives_next_o = lives_d;
    assign hit_o        = hit;

endmodule

// File: rtl/rain_collide.sv
// Two-player rain collision game core: samples sprite positions once per frame,
// applies hits through two trackers and latches the winner when a player runs out of lives.
module rain_collide
    import rain_collide_pkg::*;
#(
    parameter int unsigned LIVES   = 3,
    parameter int unsigned IFRAMES = 60
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       restart,
    input  logic       frame,
    input  logic [7:0] p1_x,
    input  logic [7:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [7:0] p2_y,
    input  logic [7:0] rain_x,
    input  logic [7:0] rain_y,
    input  logic       rain_valid,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       game_over,
    output logic [1:0] winner
);

    state_e     state_q, state_d;
    logic [1:0] winner_q, winner_d;

    logic [7:0] s_p1x_q, s_p1y_q, s_p2x_q, s_p2y_q, s_rx_q, s_ry_q, prev_ry_q;
    logic       s_rv_q, prev_rv_q;

    logic       apply;
    logic       new_drop;
    logic [1:0] p1_next, p2_next;

    assign apply    = (state_q == ST_APPLY);
    assign new_drop = apply && ((s_ry_q < prev_ry_q) || (s_rv_q && !prev_rv_q));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_p1x_q   <= '0;
            s_p1y_q   <= '0;
            s_p2x_q   <= '0;
            s_p2y_q   <= '0;
            s_rx_q    <= '0;
            s_ry_q    <= '0;
            s_rv_q    <= 1'b0;
            prev_ry_q <= '0;
            prev_rv_q <= 1'b0;
        end else if (state_q == ST_SAMPLE) begin
            s_p1x_q   <= p1_x;
            s_p1y_q   <= p1_y;
            s_p2x_q   <= p2_x;
            s_p2y_q   <= p2_y;
            s_rx_q    <= rain_x;
            s_ry_q    <= rain_y;
            s_rv_q    <= rain_valid;
            prev_ry_q <= s_ry_q;
            prev_rv_q <= s_rv_q;
        end
    end

    player_hit_tracker #(.LIVES(LIVES), .IFRAMES(IFRAMES)) u_p1 (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .restart_ni   (restart),
        .frame_i      (frame),
        .apply_i      (apply),
        .new_drop_i   (new_drop),
        .rain_valid_i (s_rv_q),
        .px_i         (s_p1x_q),
        .py_i         (s_p1y_q),
        .rx_i         (s_rx_q),
        .ry_i         (s_ry_q),
        .lives_o      (p1_lives),
        .lives_next_o (p1_next),
        .hit_o        (p1_hit)
    );

    player_hit_tracker #(.LIVES(LIVES), .IFRAMES(IFRAMES)) u_p2 (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .restart_ni   (restart),
        .frame_i      (frame),
        .apply_i      (apply),
        .new_drop_i   (new_drop),
        .rain_valid_i (s_rv_q),
        .px_i         (s_p2x_q),
        .py_i         (s_p2y_q),
        .rx_i         (s_rx_q),
        .ry_i         (s_ry_q),
        .lives_o      (p2_lives),
        .lives_next_o (p2_next),
        .hit_o        (p2_hit)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (!restart) begin
            state_d  = ST_PLAY;
            winner_d = WINNER_NONE;
        end else begin
            unique case (state_q)
                ST_PLAY:   if (frame) state_d = ST_SAMPLE;
                ST_SAMPLE: state_d = ST_APPLY;
                ST_APPLY: begin
                    // Winner is judged on the post-hit lives so it latches on the same edge.
                    if ((p1_next == '0) || (p2_next == '0)) begin
                        state_d = ST_OVER;
                        if ((p1_next == '0) && (p2_next == '0)) winner_d = WINNER_TIE;
                        else if (p1_next == '0)                winner_d = WINNER_P2;
                        else                                   winner_d = WINNER_P1;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER:   state_d = ST_OVER;
                default:   state_d = ST_PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_PLAY;
            winner_q <= WINNER_NONE;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    assign game_over = (state_q == ST_OVER);
    assign winner    = winner_q;

endmodule

// File: tb/tb_rain_collide.sv
// Directed scoreboard bench for rain_collide (LIVES=3, IFRAMES=2): stimulus queues expected
// hit events, a negedge monitor pops and compares them whenever a hit pulse appears.
module tb_rain_collide;

    logic       clk = 1'b0;
    logic       resetn, restart, frame, rain_valid;
    logic [7:0] p1_x, p1_y, p2_x, p2_y, rain_x, rain_y;
    logic [1:0] p1_lives, p2_lives, winner;
    logic       p1_hit, p2_hit, game_over;

    typedef struct {
        logic        h1;
        logic        h2;
        logic [1:0]  l1;
        logic [1:0]  l2;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    rain_collide #(.LIVES(3), .IFRAMES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .restart    (restart),
        .frame      (frame),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p2_x       (p2_x),
        .p2_y       (p2_y),
        .rain_x     (rain_x),
        .rain_y     (rain_y),
        .rain_valid (rain_valid),
        .p1_lives   (p1_lives),
        .p2_lives   (p2_lives),
        .p1_hit     (p1_hit),
        .p2_hit     (p2_hit),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] l1, input logic [1:0] l2,
                                input logic go, input logic [1:0] w);
        check({tag, "_p1_lives"}, 32'(p1_lives), 32'(l1));
        check({tag, "_p2_lives"}, 32'(p2_lives), 32'(l2));
        check({tag, "_game_over"}, 32'(game_over), 32'(go));
        check({tag, "_winner"}, 32'(winner), 32'(w));
    endtask

    // One animation frame; a hit (if any) is due at the negedge two cycles after frame is raised.
    task automatic do_frame(input logic e1, input logic e2, input logic [1:0] l1, input logic [1:0] l2);
        @(posedge clk); #1;
        if (e1 || e2) exp_q.push_back('{h1: e1, h2: e2, l1: l1, l2: l2, cyc: cyc + 2});
        frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        @(posedge clk); #1;
        restart = 1'b0;
        @(posedge clk); #1;
        restart = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (resetn && (p1_hit || p2_hit)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_hit: got p1_hit=%0b p2_hit=%0b at cycle %0d, required no hit",
                             p1_hit, p2_hit, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("hit_vector", 32'({p1_hit, p2_hit, p1_lives, p2_lives}),
                          32'({mon_e.h1, mon_e.h2, mon_e.l1, mon_e.l2}));
                    check("hit_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; restart = 1'b1; frame = 1'b0; rain_valid = 1'b0;
        p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0; rain_x = '0; rain_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset", 2'd3, 2'd3, 1'b0, 2'b00);
        check("reset_hits", 32'({p1_hit, p2_hit}), 32'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic overlap hit on player 1
        p1_x = 8'd100; p1_y = 8'd110; p2_x = 8'd10; p2_y = 8'd10;
        rain_x = 8'd101; rain_y = 8'd104; rain_valid = 1'b1;
        do_frame(1'b1, 1'b0, 2'd3, 2'd3);
        check("first_hit_p1_lives", 32'(p1_lives), 32'd2);

        // Same drop held for five frames: latch suppresses further hits
        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        check("held_drop_p1_lives", 32'(p1_lives), 32'd2);

        // Drop falls onto player 2
        rain_y = 8'd118; p2_x = 8'd101; p2_y = 8'd120;
        do_frame(1'b0, 1'b1, 2'd2, 2'd3);
        check("p2_hit_lives", 32'(p2_lives), 32'd2);

        // New drop (118 -> 0) overlapping while still immune: no hit
        rain_y = 8'd0; p2_y = 8'd2;
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        check("immune_p2_lives", 32'(p2_lives), 32'd2);

        // Rain off screen, then a fresh overlapping drop on the third frame after the hit
        rain_valid = 1'b0;
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        rain_valid = 1'b1;
        do_frame(1'b0, 1'b1, 2'd2, 2'd2);
        check("third_frame_p2_lives", 32'(p2_lives), 32'd1);

        // Right-edge wrap: rain at x=0 must not touch a sprite at x=254
        rain_valid = 1'b0;
        p2_x = 8'd254; p2_y = 8'd110;
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        rain_valid = 1'b1; rain_x = 8'd0; rain_y = 8'd104;
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        check("wrap_no_hit_lives", 32'(p2_lives), 32'd1);
        rain_x = 8'd255;
        do_frame(1'b0, 1'b1, 2'd2, 2'd1);
        check_status("p2_out", 2'd2, 2'd0, 1'b1, 2'b01);

        // Frames in the over state are ignored even with a would-be hit on player 1
        p1_x = 8'd254; p1_y = 8'd104;
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        check_status("over_hold", 2'd2, 2'd0, 1'b1, 2'b01);

        do_restart();
        check_status("restart1", 2'd3, 2'd3, 1'b0, 2'b00);

        // Both players hit together three times -> tie
        p1_x = 8'd50; p1_y = 8'd50; p2_x = 8'd51; p2_y = 8'd52;
        rain_x = 8'd50; rain_y = 8'd46;
        for (int i = 0; i < 3; i++) begin
            rain_valid = 1'b1;
            do_frame(1'b1, 1'b1, 2'(3 - i), 2'(3 - i));
            rain_valid = 1'b0;
            do_frame(1'b0, 1'b0, 2'd0, 2'd0);
            do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        end
        check_status("tie", 2'd0, 2'd0, 1'b1, 2'b11);

        do_restart();
        check_status("restart2", 2'd3, 2'd3, 1'b0, 2'b00);

        // Post-restart hit, then reset asserted in the middle of APPLY
        p2_x = 8'd200; p2_y = 8'd10; rain_valid = 1'b1;
        do_frame(1'b1, 1'b0, 2'd3, 2'd3);
        check("post_restart_p1_lives", 32'(p1_lives), 32'd2);
        rain_valid = 1'b0;
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        do_frame(1'b0, 1'b0, 2'd0, 2'd0);
        rain_valid = 1'b1;
        @(posedge clk); #1;
        frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check_status("reset_in_apply", 2'd3, 2'd3, 1'b0, 2'b00);
        check("reset_in_apply_hits", 32'({p1_hit, p2_hit}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // First frame after reset is processed normally
        do_frame(1'b1, 1'b0, 2'd3, 2'd3);
        check("after_reset_p1_lives", 32'(p1_lives), 32'd2);

        repeat (4) @(posedge clk);
        #1;
        check("pending_hits", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
